// File: rtl/csr_cfg_loader.sv
// rtl/csr_cfg_loader.sv - streams NUM_CSR config words from block RAM into csr registers
// Issues reads, tracks them through a RD_LATENCY-deep pipeline, and strobes each returning word.
module csr_cfg_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CSR    = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [NUM_CSR-1:0]    csr_set,
  output logic [DATA_WIDTH-1:0] csr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CSR - 1);
  localparam logic [NUM_CSR-1:0] ONE_HOT0 = NUM_CSR'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  state_t                r_state;
  logic                  r_mem_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [IDX_W-1:0]      r_cnt;
  logic [NUM_CSR-1:0]    r_csr_set;
  logic [DATA_WIDTH-1:0] r_csr_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pipe_vld [RD_LATENCY];
  logic [IDX_W-1:0]      r_pipe_idx [RD_LATENCY];
  logic [NUM_CSR-1:0]    w_onehot;

  assign w_onehot = ONE_HOT0 << r_pipe_idx[RD_LATENCY-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_csr_set  <= '0;
      r_csr_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;

      // Stage 0 captures the read issued this cycle; the last stage lines up with mem_dout.
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
      r_pipe_vld[0] <= r_mem_en;
      r_pipe_idx[0] <= r_cnt;

      if (r_pipe_vld[RD_LATENCY-1]) begin
        r_csr_set  <= w_onehot;
        r_csr_data <= mem_dout;
      end else begin
        r_csr_set  <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_ISSUE;
            r_busy     <= 1'b1;
            r_mem_en   <= 1'b1;
            r_mem_addr <= base_addr;
            r_cnt      <= '0;
          end
        end
        ST_ISSUE: begin
          if (r_cnt == LAST_IDX) begin
            r_state  <= ST_DRAIN;
            r_mem_en <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + IDX_W'(1);
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (r_csr_set[NUM_CSR-1]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Cancel drops in-flight reads; csrs already strobed keep their new values.
      if (abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_mem_en  <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_csr_set <= '0;
        for (int i = 0; i < RD_LATENCY; i++) r_pipe_vld[i] <= 1'b0;
      end
    end
  end

  assign mem_en   = r_mem_en;
  assign mem_addr = r_mem_addr;
  assign csr_set  = r_csr_set;
  assign csr_data = r_csr_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_csr_cfg_loader.sv
// tb/tb_csr_cfg_loader.sv - directed self-checking bench for csr_cfg_loader
// Two instances: default parameters, and NUM_CSR=1 / RD_LATENCY=1.
module tb_csr_cfg_loader;

  logic        clk;
  logic        rstn;
  logic        start, abort;
  logic [9:0]  base_addr;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_dout;
  logic [7:0]  csr_set;
  logic [31:0] csr_data;
  logic        busy, done;

  logic        start2;
  logic        mem_en2;
  logic [9:0]  mem_addr2;
  logic [31:0] mem_dout2;
  logic [0:0]  csr_set2;
  logic [31:0] csr_data2;
  logic        busy2, done2;

  logic [31:0] r_d1, r_d2, r_d1b;
  int          cyc, t0;
  int          n_chk, n_fail;

  logic        s_en   [32];
  logic [9:0]  s_addr [32];
  logic [7:0]  s_set  [32];
  logic [31:0] s_data [32];
  logic        s_busy [32];
  logic        s_done [32];

  csr_cfg_loader u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .base_addr(base_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .csr_set(csr_set), .csr_data(csr_data), .busy(busy), .done(done)
  );

  csr_cfg_loader #(.NUM_CSR(1), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0), .base_addr(10'h3C0),
    .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_dout(mem_dout2),
    .csr_set(csr_set2), .csr_data(csr_data2), .busy(busy2), .done(done2)
  );

  function automatic logic [31:0] ram_word(input logic [9:0] a);
    return 32'hA000_0000 + 32'(a) - 32'h40;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en)  r_d1  <= ram_word(mem_addr);
    r_d2 <= r_d1;
    if (mem_en2) r_d1b <= ram_word(mem_addr2);
  end
  assign mem_dout  = r_d2;
  assign mem_dout2 = r_d1b;

  always @(negedge clk) begin : mon
    int r;
    r = cyc - t0;
    if (r >= 0 && r < 32) begin
      s_en[r]   = mem_en;
      s_addr[r] = mem_addr;
      s_set[r]  = csr_set;
      s_data[r] = csr_data;
      s_busy[r] = busy;
      s_done[r] = done;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [9:0] b);
    for (int i = 0; i < 32; i++) begin
      s_en[i] = 1'bx; s_set[i] = 'x; s_busy[i] = 1'bx; s_done[i] = 1'bx;
    end
    start = 1'b1;
    base_addr = b;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic check_nominal(input logic [9:0] b, input string nm);
    logic [7:0] es;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("%s en c%0d", nm, c), 32'(s_en[c]), 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8)
        check($sformatf("%s addr c%0d", nm, c), 32'(s_addr[c]), 32'(10'(b + 10'(c - 1))));
      es = (c >= 4 && c <= 11) ? (8'd1 << (c - 4)) : 8'd0;
      check($sformatf("%s set c%0d", nm, c), 32'(s_set[c]), 32'(es));
      if (es != 0)
        check($sformatf("%s data c%0d", nm, c), s_data[c], ram_word(10'(b + 10'(c - 4))));
      if (c >= 1)
        check($sformatf("%s done c%0d", nm, c), 32'(s_done[c]), 32'(c == 12));
      check($sformatf("%s busy c%0d", nm, c), 32'(s_busy[c]), 32'(c >= 1 && c <= 11));
    end
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    base_addr = '0; cyc = 0; t0 = -1000; n_chk = 0; n_fail = 0;
    r_d1 = '0; r_d2 = '0; r_d1b = '0;
    #3;
    check("rst mem_en", 32'(mem_en), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst csr_set", 32'(csr_set), 0);
    check("rst csr_data", csr_data, 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    repeat (3) step();
    rstn = 1'b1;
    repeat (2) step();

    go(10'h040);
    repeat (16) step();
    check_nominal(10'h040, "t1");

    go(10'h3FE);
    repeat (16) step();
    check_nominal(10'h3FE, "t2");
    check("t2 set2 data", s_data[6], ram_word(10'h000));

    go(10'h040);
    repeat (4) step();
    start = 1'b1; base_addr = 10'h100;
    step();
    start = 1'b0; base_addr = 10'h040;
    repeat (11) step();
    check_nominal(10'h040, "t3");
    for (int c = 0; c < 20; c++)
      if (s_en[c] === 1'b1) check($sformatf("t3 no 0x100 c%0d", c), 32'(s_addr[c] == 10'h100), 0);

    go(10'h040);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (10) step();
    check("t4 set c4", 32'(s_set[4]), 32'h1);
    check("t4 set c5", 32'(s_set[5]), 32'h2);
    check("t4 set c6", 32'(s_set[6]), 32'h4);
    check("t4 busy c7", 32'(s_busy[7]), 0);
    check("t4 en c7", 32'(s_en[7]), 0);
    for (int c = 7; c < 17; c++) begin
      check($sformatf("t4 set c%0d", c), 32'(s_set[c]), 0);
      check($sformatf("t4 done c%0d", c), 32'(s_done[c]), 0);
    end
    go(10'h040);
    repeat (16) step();
    check_nominal(10'h040, "t4b");

    go(10'h040);
    repeat (11) step();
    check("t6 done1", 32'(done), 1);
    go(10'h080);
    repeat (16) step();
    check_nominal(10'h080, "t6");

    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      check($sformatf("t6s en r%0d", r), 32'(mem_en2), 32'(r == 1));
      check($sformatf("t6s set r%0d", r), 32'(csr_set2), 32'(r == 3));
      check($sformatf("t6s done r%0d", r), 32'(done2), 32'(r == 4));
      if (r == 3) check("t6s data", csr_data2, ram_word(10'h3C0));
      step();
    end

    go(10'h040);
    repeat (9) step();
    rstn = 1'b0;
    #1;
    check("t5 csr_set", 32'(csr_set), 0);
    check("t5 mem_en", 32'(mem_en), 0);
    check("t5 busy", 32'(busy), 0);
    check("t5 done", 32'(done), 0);
    repeat (2) step();
    rstn = 1'b1;
    for (int r = 0; r < 12; r++) begin
      check($sformatf("t5 post set r%0d", r), 32'(csr_set), 0);
      check($sformatf("t5 post done r%0d", r), 32'(done), 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_cfg_loader.md
Name: csr_cfg_loader

Overview:
Configuration sequencer that sits directly upstream of the accelerator's bank of csr registers. On a start request it streams NUM_CSR consecutive configuration words out of a block RAM, starting at a runtime base address. It then drives each word onto the shared csr data bus with a one-hot per-register set strobe. It pulses done once every register has been loaded, so the conv datapath can start with a coherent configuration.

Parameters:
DATA_WIDTH, 32, width of each config word and of every csr.
ADDR_WIDTH, 10, block RAM address width.
NUM_CSR, 8, number of csr registers loaded per sequence (>=1).
RD_LATENCY, 2, block RAM read latency in cycles from en/addr to valid mem_dout (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle load request, honoured only in IDLE
abort  input  1  synchronous cancel of an in-progress load
base_addr  input  ADDR_WIDTH  RAM address of config word 0, sampled with start
mem_en  output  1  block RAM read enable
mem_addr  output  ADDR_WIDTH  block RAM read address
mem_dout  input  DATA_WIDTH  block RAM read data, valid RD_LATENCY cycles after en
csr_set  output  NUM_CSR  one-hot load strobe, bit i drives set of csr i
csr_data  output  DATA_WIDTH  shared csr_in bus for all csr instances
busy  output  1  load sequence in progress
done  output  1  one-cycle pulse: all NUM_CSR registers written

Behaviour:
- Reset (rstn low, asynchronous): state IDLE. mem_en=0, mem_addr=0, csr_set=0, csr_data=0, busy=0, done=0. In-flight tracking pipeline cleared. Reset mid-sequence abandons the sequence with no further strobes.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 at edge T0 latches base_addr and clears the issue counter.
  - Next state is ISSUE.
  - busy=1 from cycle T0+1.
- ISSUE:
  - In cycle k (k=1..NUM_CSR after T0): mem_en=1, mem_addr=base_addr+(k-1), modulo 2^ADDR_WIDTH. Wrap-around is legal.
  - On the last issue, go to DRAIN. mem_en=0 from the following cycle.
- Tracking pipeline: RD_LATENCY-deep shift register of {valid, index}, where index is $clog2(NUM_CSR) bits (min 1). It is loaded on each issue cycle.
- Write-back timing:
  - A word addressed in cycle k appears on mem_dout in cycle k+RD_LATENCY.
  - At the end of that cycle, csr_data<=mem_dout and csr_set<=onehot(index).
  - The strobe is therefore visible in cycle k+RD_LATENCY+1, exactly one cycle wide.
  - csr_set=0 whenever no valid word returns. csr_data holds its last value when csr_set=0.
- DRAIN: waits until the last strobe (index NUM_CSR-1) has been driven.
- Completion:
  - In the cycle after the last strobe: done=1 for one cycle, busy=0, state IDLE.
  - Total latency from start edge to done is NUM_CSR+RD_LATENCY+2 cycles.
- Strobes are issued in strictly ascending index order, one per cycle with no gaps. At most one csr_set bit is high in any cycle.
- start while busy=1 is ignored (no restart, no queueing).
- start in the done cycle is accepted, because the FSM is already IDLE; back-to-back sequences are allowed.
- abort=1 while busy (ISSUE or DRAIN):
  - Next cycle: state IDLE, mem_en=0, pipeline valids cleared, csr_set=0, busy=0, done stays 0.
  - Registers already strobed keep their new values. There is no rollback.
- abort in IDLE has no effect. abort and start together in IDLE: start wins.
- mem_dout is ignored unless a tracked valid read is returning.

Test Plan:
1. Nominal load (defaults): base_addr=0x040, RAM[0x040+i]=0xA000_0000+i, start at T0 -> mem_addr 0x040..0x047 with mem_en=1 in cycles 1..8; csr_set=1<<i with csr_data=0xA000_0000+i in cycle 4+i (i=0..7); done=1 only in cycle 12; busy=1 in cycles 1..11.
2. Address wrap: base_addr=0x3FE -> mem_addr sequence 0x3FE, 0x3FF, 0x000..0x005; csr_set[2] carries RAM[0x000].
3. Start while busy: second start pulse in cycle 5 with base_addr=0x100 -> no address 0x100 ever issued; single done in cycle 12.
4. Abort: abort=1 in cycle 6 -> csr_set[0], csr_set[1] and csr_set[2] seen in cycles 4-6; nothing from cycle 7; done never asserts; busy=0 from cycle 7; a fresh start then completes normally.
5. Async reset mid-DRAIN: rstn low in cycle 10 -> csr_set, mem_en, busy, done all 0 immediately without waiting for clk; no strobes after rstn rises.
6. Back-to-back plus parameter sweep: start in done cycle -> second sequence issues from the next cycle. Repeat with NUM_CSR=1 and RD_LATENCY=1 -> done exactly 4 cycles after start.
